id_ex_operand_stage: RTL and testbench
======================================

# id_ex_operand_stage

ID/EX pipeline register and operand-select stage sitting directly upstream of the execute-stage ALU. It captures decoded instruction fields each cycle and resolves RAW hazards by forwarding results from the MEM and WB stages. It selects register or immediate for the ALU B operand and detects load-use hazards, inserting a bubble when one occurs. Its outputs drive the ALU operand inputs, the 3-bit ALU control, and the EX/MEM control fields.

## Interface
- WIDTH, 32, datapath width
- REG_AW, 5, register-address width
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- stall  in  1  downstream hold; stage register keeps its contents
- flush  in  1  squash; stage register loads a bubble
- id_valid  in  1  ID slot holds a real instruction
- id_rs1, id_rs2, id_rd  in  REG_AW  register addresses
- id_rs1_data, id_rs2_data, id_imm  in  WIDTH  register-file reads and sign-extended immediate
- id_alu_src  in  1  1: B operand = immediate
- id_alu_control  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 xor, 101 slt, 110 or)
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- mem_rd / wb_rd  in  REG_AW; mem_reg_write / wb_reg_write  in  1; mem_result / wb_result  in  WIDTH  forwarding sources
- ex_valid  out  1  EX slot valid
- alu_a, alu_b  out  WIDTH  ALU operands (post-forwarding)
- ex_alu_control  out  3; ex_rd  out  REG_AW; ex_reg_write, ex_mem_read, ex_mem_write  out  1
- ex_store_data  out  WIDTH  forwarded rs2 value, for stores
- load_use_stall  out  1  IF/ID must hold this cycle

## Operation
- Stage register: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_src, alu_control, reg_write, mem_read, mem_write.
- Next-state priority, evaluated per rising edge:
  - flush: load a bubble.
  - stall: hold all fields.
  - load_use_stall: load a bubble.
  - otherwise: load the ID fields.
- Bubble: valid=0, reg_write=mem_read=mem_write=0, rd=0, all data fields 0, alu_control=000.
- Load-use hazard: load_use_stall = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2). This output is combinational.
- Forwarding for operand X ∈ {rs1, rs2}:
  - Use mem_result if mem_reg_write & mem_rd≠0 & mem_rd==X.
  - Else use wb_result if wb_reg_write & wb_rd≠0 & wb_rd==X.
  - Else use the registered data.
  - MEM has priority over WB. x0 is never forwarded.
- alu_a = fwd(rs1). alu_b = alu_src ? imm : fwd(rs2). ex_store_data = fwd(rs2) regardless of alu_src.
- All arithmetic is pass-through only; no width change. Addresses are compared at exactly REG_AW bits.
- ex_* control outputs come straight from the stage register.

## Timing
- Reset (async, resetn=0): stage register holds the bubble. Outputs: ex_valid=0, alu_a=alu_b=ex_store_data=0 (given no forwarding match), ex_alu_control=000, ex_rd=0, all control bits 0, load_use_stall=0.
- Release of resetn is synchronised externally; the first capture happens on the first rising edge with resetn=1.
- Latency: ID fields appear on ex_* outputs one cycle after capture.
- alu_a, alu_b, ex_store_data and load_use_stall are combinational in the same cycle from the register and mem_*/wb_*.
- A load-use hazard costs exactly one bubble. On the next cycle the load has moved on, so the hazard clears and the consumer is captured.
- stall + load_use_stall: the stage holds and load_use_stall stays asserted.
- flush + stall: flush wins.
- flush + load_use_stall: bubble (same result either way).
- resetn asserted mid-operation: the bubble is loaded immediately, independent of clk.

## Configuration
- FORWARDING_EN defined:
  - Forwarding as described above.
- FORWARDING_EN undefined:
  - No forwarding; alu_a, alu_b and ex_store_data use registered data only. mem_*/wb_* inputs are ignored.
  - load_use_stall widens to any RAW hazard: ex_valid & ex_reg_write & ex_rd≠0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2). Loads are included.
  - MEM/WB-distance hazards are the upstream stage's responsibility.

## Test plan
- Reset: hold resetn=0 for 3 cycles with arbitrary inputs -> ex_valid=0, ex_rd=0, ex_alu_control=000, alu_a=alu_b=0.
- Basic capture: id_rs1_data=5, id_imm=7, alu_src=1, alu_control=000, rd=3 -> next cycle alu_a=5, alu_b=7, ex_rd=3, ex_valid=1.
- Forwarding priority (FORWARDING_EN): ex_rs1=4, mem_rd=4 with mem_result=0x11, wb_rd=4 with wb_result=0x22 -> alu_a=0x11. Drop mem_reg_write -> alu_a=0x22. Set rs1=0 with mem_rd=0 -> alu_a = registered value.
- Load-use: EX holds a lw to rd=6, ID has add with rs2=6 -> load_use_stall=1 for one cycle, ex_valid=0 on the next cycle, then the add is captured and load_use_stall=0.
- Stall/flush: stall=1 for 2 cycles -> outputs unchanged. stall=1 with flush=1 -> next cycle ex_valid=0, ex_reg_write=0.
- No-forwarding build: ex add rd=2 with id rs1=2 -> load_use_stall=1, and mem_result is not visible on alu_a.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand select, MEM/WB forwarding and
// load-use hazard detection, feeding the execute-stage ALU.
// Optional feature macro: FORWARDING_EN. When it is defined, MEM/WB results
// are forwarded. When it is undefined, operands come from the stage register
// only, and any RAW hazard against EX stalls.
module id_ex_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [WIDTH-1:0]  id_rs1_data,
  input  logic [WIDTH-1:0]  id_rs2_data,
  input  logic [WIDTH-1:0]  id_imm,
  input  logic              id_alu_src,
  input  logic [2:0]        id_alu_control,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [WIDTH-1:0]  mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [WIDTH-1:0]  wb_result,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        ex_alu_control,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [WIDTH-1:0]  ex_store_data,
  output logic              load_use_stall
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [WIDTH-1:0]  imm;
    logic              alu_src;
    logic [2:0]        alu_control;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } stage_t;

  // An all-zero stage is the bubble: invalid, no side effects, x0 target.
  localparam stage_t BUBBLE = '0;

  stage_t q, id_stage;
  logic   rs_hit;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  assign id_stage = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                      rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                      alu_src: id_alu_src, alu_control: id_alu_control,
                      reg_write: id_reg_write, mem_read: id_mem_read,
                      mem_write: id_mem_write};

  // The instruction in ID reads the register that the instruction in EX writes.
  assign rs_hit = q.valid & (q.rd != '0) & id_valid &
                  ((q.rd == id_rs1) | (q.rd == id_rs2));

`ifdef FORWARDING_EN
  // MEM is younger than WB, so it is checked first. x0 is never forwarded.
  always_comb begin
    fwd_a = q.rs1_data;
    fwd_b = q.rs2_data;
    if (mem_reg_write && mem_rd != '0 && mem_rd == q.rs1)   fwd_a = mem_result;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == q.rs1) fwd_a = wb_result;
    if (mem_reg_write && mem_rd != '0 && mem_rd == q.rs2)   fwd_b = mem_result;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == q.rs2) fwd_b = wb_result;
  end

  // Only a load's result arrives too late to forward.
  assign load_use_stall = rs_hit & q.mem_read;
`else
  assign fwd_a = q.rs1_data;
  assign fwd_b = q.rs2_data;

  // Without forwarding, every producer in EX blocks a dependent consumer.
  assign load_use_stall = rs_hit & q.reg_write;

  logic unused_fwd;
  assign unused_fwd = ^{mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write,
                        wb_result, q.rs1, q.rs2};
`endif

  // Stage register: flush > stall (hold) > load-use bubble > capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             q <= BUBBLE;
    else if (flush)          q <= BUBBLE;
    else if (stall)          q <= q;
    else if (load_use_stall) q <= BUBBLE;
    else                     q <= id_stage;
  end

  assign ex_valid       = q.valid;
  assign alu_a          = fwd_a;
  assign alu_b          = q.alu_src ? q.imm : fwd_b;
  assign ex_store_data  = fwd_b;
  assign ex_alu_control = q.alu_control;
  assign ex_rd          = q.rd;
  assign ex_reg_write   = q.reg_write;
  assign ex_mem_read    = q.mem_read;
  assign ex_mem_write   = q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage. It covers the default build and the
// FORWARDING_EN build.
module tb_id_ex_operand_stage;
  logic        clk = 1'b0;
  logic        resetn, stall, flush;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [2:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .ex_alu_control(ex_alu_control), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic src, input logic [2:0] ctl,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_alu_src = src; id_alu_control = ctl;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic clr_id();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_fwd();
    mem_rd = 5'd0; mem_reg_write = 1'b0; mem_result = 32'd0;
    wb_rd = 5'd0;  wb_reg_write = 1'b0;  wb_result = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; stall = 1'b0; flush = 1'b0; clr_fwd();
    set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'hAAAA, 32'hBBBB, 32'hCCCC, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", ex_rd); end
    checks++; if (ex_alu_control !== 3'b000) begin errors++; $display("FAIL reset_ctl got=%b exp=000", ex_alu_control); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || ex_store_data !== 32'd0) begin
      errors++; $display("FAIL reset_data got a=%h b=%h sd=%h exp=0", alu_a, alu_b, ex_store_data); end
    checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall}); end
    clr_id();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd9, 32'd7, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin
      errors++; $display("FAIL basic_ctrl got v=%0b rd=%0d rw=%0b exp v=1 rd=3 rw=1", ex_valid, ex_rd, ex_reg_write); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
      errors++; $display("FAIL basic_ops got a=%0d b=%0d exp a=5 b=7", alu_a, alu_b); end
    checks++; if (ex_store_data !== 32'd9) begin
      errors++; $display("FAIL basic_store got=%0d exp=9", ex_store_data); end
    set_id(1'b1, 5'd4, 5'd5, 5'd7, 32'hA, 32'hB, 32'hC, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (load_use_stall !== 1'b0) begin
      errors++; $display("FAIL basic_nohaz got=%0b exp=0", load_use_stall); end
    tick();
    checks++; if (alu_a !== 32'hA || alu_b !== 32'hB || ex_store_data !== 32'hB) begin
      errors++; $display("FAIL regsrc_ops got a=%h b=%h sd=%h exp a=a b=b sd=b", alu_a, alu_b, ex_store_data); end
    checks++; if (ex_alu_control !== 3'b011 || ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL regsrc_ctrl got ctl=%b mw=%0b rw=%0b exp ctl=011 mw=1 rw=0", ex_alu_control, ex_mem_write, ex_reg_write); end
    clr_id(); tick();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd1, 5'd0, 5'd6, 32'd100, 32'd0, 32'd4, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 5'd6, 5'd8, 32'h20, 32'h30, 32'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (load_use_stall !== 1'b1) begin
      errors++; $display("FAIL lu_detect got=%0b exp=1", load_use_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      errors++; $display("FAIL lu_bubble got v=%0b rw=%0b mr=%0b exp 0", ex_valid, ex_reg_write, ex_mem_read); end
    checks++; if (load_use_stall !== 1'b0) begin
      errors++; $display("FAIL lu_clear got=%0b exp=0", load_use_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || alu_a !== 32'h20 || alu_b !== 32'h30) begin
      errors++; $display("FAIL lu_capture got v=%0b rd=%0d a=%h b=%h exp v=1 rd=8 a=20 b=30", ex_valid, ex_rd, alu_a, alu_b); end
    clr_id(); tick();
  endtask

  task automatic test_x0();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 32'd0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (load_use_stall !== 1'b0) begin
      errors++; $display("FAIL x0_nohaz got=%0b exp=0", load_use_stall); end
    clr_id(); tick();
  endtask

  task automatic test_stall_flush();
    set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'h55, 32'h66, 32'h77, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd10, 5'd11, 5'd12, 32'd1, 32'd2, 32'd3, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1);
    stall = 1'b1;
    tick(); tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_alu_control !== 3'b110 || ex_mem_write !== 1'b0) begin
      errors++; $display("FAIL stall_ctrl got v=%0b rd=%0d ctl=%b mw=%0b exp v=1 rd=9 ctl=110 mw=0", ex_valid, ex_rd, ex_alu_control, ex_mem_write); end
    checks++; if (alu_a !== 32'h55 || alu_b !== 32'h77 || ex_store_data !== 32'h66) begin
      errors++; $display("FAIL stall_ops got a=%h b=%h sd=%h exp a=55 b=77 sd=66", alu_a, alu_b, ex_store_data); end
    flush = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || alu_a !== 32'd0) begin
      errors++; $display("FAIL flush_wins got v=%0b rw=%0b rd=%0d a=%h exp 0", ex_valid, ex_reg_write, ex_rd, alu_a); end
    stall = 1'b0; flush = 1'b0; clr_id(); tick();
  endtask

  task automatic test_stall_hazard();
    set_id(1'b1, 5'd1, 5'd0, 5'd6, 32'd0, 32'd0, 32'd8, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd6, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || ex_rd !== 5'd6 || load_use_stall !== 1'b1) begin
      errors++; $display("FAIL stall_lu got v=%0b mr=%0b rd=%0d lus=%0b exp v=1 mr=1 rd=6 lus=1", ex_valid, ex_mem_read, ex_rd, load_use_stall); end
    stall = 1'b0; flush = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin
      errors++; $display("FAIL flush_lu got v=%0b rd=%0d exp v=0 rd=0", ex_valid, ex_rd); end
    flush = 1'b0; clr_id(); tick();
  endtask

  task automatic test_async_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 32'h123, 32'h456, 32'd0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
    tick();
    clr_id();
    #2 resetn = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || alu_a !== 32'd0 || ex_alu_control !== 3'b000) begin
      errors++; $display("FAIL async_reset got v=%0b rd=%0d a=%h ctl=%b exp 0", ex_valid, ex_rd, alu_a, ex_alu_control); end
    resetn = 1'b1;
    tick();
  endtask

`ifdef FORWARDING_EN
  task automatic test_forward();
    set_id(1'b1, 5'd4, 5'd5, 5'd7, 32'h99, 32'h55, 32'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    clr_id();
    mem_rd = 5'd4; mem_reg_write = 1'b1; mem_result = 32'h11;
    wb_rd = 5'd4;  wb_reg_write = 1'b1;  wb_result = 32'h22;
    #1;
    checks++; if (alu_a !== 32'h11) begin errors++; $display("FAIL fwd_mem_prio got=%h exp=11", alu_a); end
    mem_reg_write = 1'b0; #1;
    checks++; if (alu_a !== 32'h22) begin errors++; $display("FAIL fwd_wb got=%h exp=22", alu_a); end
    wb_rd = 5'd5; #1;
    checks++; if (alu_b !== 32'h22 || ex_store_data !== 32'h22 || alu_a !== 32'h99) begin
      errors++; $display("FAIL fwd_rs2 got a=%h b=%h sd=%h exp a=99 b=22 sd=22", alu_a, alu_b, ex_store_data); end
    clr_fwd(); tick();
    set_id(1'b1, 5'd0, 5'd1, 5'd7, 32'h33, 32'd0, 32'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    clr_id();
    mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'h11;
    wb_rd = 5'd0;  wb_reg_write = 1'b1;  wb_result = 32'h22;
    #1;
    checks++; if (alu_a !== 32'h33) begin errors++; $display("FAIL fwd_x0 got=%h exp=33", alu_a); end
    clr_fwd();
    set_id(1'b1, 5'd7, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (load_use_stall !== 1'b0) begin
      errors++; $display("FAIL fwd_alu_nostall got=%0b exp=0", load_use_stall); end
    clr_id(); tick();
  endtask
`else
  task automatic test_no_forward();
    set_id(1'b1, 5'd1, 5'd3, 5'd2, 32'h44, 32'h66, 32'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (load_use_stall !== 1'b1) begin
      errors++; $display("FAIL nofwd_raw_stall got=%0b exp=1", load_use_stall); end
    mem_rd = 5'd1; mem_reg_write = 1'b1; mem_result = 32'hDEAD;
    wb_rd = 5'd3;  wb_reg_write = 1'b1;  wb_result = 32'hBEEF;
    #1;
    checks++; if (alu_a !== 32'h44 || alu_b !== 32'h66 || ex_store_data !== 32'h66) begin
      errors++; $display("FAIL nofwd_ops got a=%h b=%h sd=%h exp a=44 b=66 sd=66", alu_a, alu_b, ex_store_data); end
    clr_fwd(); clr_id(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_load_use();
    test_x0();
    test_stall_flush();
    test_stall_hazard();
`ifdef FORWARDING_EN
    test_forward();
`else
    test_no_forward();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
